// File: rtl/dds_cfg_pkg.sv
// Shared types and constants for the DDS configuration master.
// The package holds the FSM state encoding, the boot-table contents and the default parameter values.
package dds_cfg_pkg;

  typedef enum logic [1:0] {
    INIT_WAIT = 2'd0,
    WRITE     = 2'd1,
    GAP       = 2'd2,
    IDLE      = 2'd3
  } cfg_state_e;

  localparam int DEF_INIT_DELAY  = 16;
  localparam int DEF_GAP_CYCLES  = 1;
  localparam int DEF_TABLE_DEPTH = 2;

  // Boot table: frequency word first, then control word.
  localparam logic [15:0] BOOT_ADDR0 = 16'h0030;
  localparam logic [15:0] BOOT_DATA0 = 16'h000F;
  localparam logic [15:0] BOOT_ADDR1 = 16'h0020;
  localparam logic [15:0] BOOT_DATA1 = 16'h0002;

  // Counter width for values 0..v-1. It never returns less than 1 bit.
  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/dds_cfg_rom.sv
// Boot-table lookup: a purely combinational mapping from index to {addr, data}.
// Indices past the table depth read back as zero.
module dds_cfg_rom
  import dds_cfg_pkg::*;
#(
  parameter int TABLE_DEPTH = DEF_TABLE_DEPTH,
  parameter int IDX_W       = clog2_min1(TABLE_DEPTH)
) (
  input  logic [IDX_W-1:0] idx,
  output logic [15:0]      addr,
  output logic [15:0]      data
);

  // Decode the index into the table entry.
  always_comb begin
    addr = '0;
    data = '0;
    if (int'(idx) < TABLE_DEPTH) begin
      case (int'(idx))
        0: begin
          addr = BOOT_ADDR0;
          data = BOOT_DATA0;
        end
        1: begin
          addr = BOOT_ADDR1;
          data = BOOT_DATA1;
        end
        default: begin
          addr = '0;
          data = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/dds_cfg_master.sv
// DDS configuration master.
// After reset it waits INIT_DELAY edges and then writes the boot table.
// Each write is a one-cycle strobe followed by GAP_CYCLES idle cycles.
// Once the table is done it sits in IDLE, where it serves single runtime writes or replays the table on start.
// Every output comes from a flop. The flops are loaded from the next-state decode, so outputs track the state
// they describe without any input-to-output combinational path.
module dds_cfg_master
  import dds_cfg_pkg::*;
#(
  parameter int INIT_DELAY  = DEF_INIT_DELAY,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int TABLE_DEPTH = DEF_TABLE_DEPTH
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        upd_valid,
  input  logic [15:0] upd_addr,
  input  logic [15:0] upd_data,
  output logic        upd_ready,
  output logic        wr,
  output logic [15:0] waddr,
  output logic [15:0] wdata,
  output logic        busy,
  output logic        done
);

  localparam int IDX_W = clog2_min1(TABLE_DEPTH);
  localparam int DLY_W = clog2_min1(INIT_DELAY + 1);
  localparam int GAP_W = clog2_min1(GAP_CYCLES);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TABLE_DEPTH - 1);
  localparam logic [DLY_W-1:0] DLY_MAX  = DLY_W'(INIT_DELAY);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  cfg_state_e       state_q, state_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  // rt_q marks that the write in flight is a runtime request rather than a table entry.
  logic             rt_q, rt_d;
  logic [15:0]      rt_addr_q, rt_addr_d;
  logic [15:0]      rt_data_q, rt_data_d;

  logic             wr_q, wr_d;
  logic [15:0]      waddr_q, waddr_d;
  logic [15:0]      wdata_q, wdata_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [15:0]      rom_addr, rom_data;

  // The ROM is indexed by the next index, so the entry is ready on the edge that enters WRITE.
  dds_cfg_rom #(
    .TABLE_DEPTH (TABLE_DEPTH),
    .IDX_W       (IDX_W)
  ) u_rom (
    .idx  (idx_d),
    .addr (rom_addr),
    .data (rom_data)
  );

  // Next-state decode plus the next output values.
  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    gap_d     = gap_q;
    idx_d     = idx_q;
    rt_d      = rt_q;
    rt_addr_d = rt_addr_q;
    rt_data_d = rt_data_q;
    done_d    = 1'b0;

    case (state_q)
      INIT_WAIT: begin
        if (dly_q == DLY_MAX) begin
          state_d = WRITE;
          idx_d   = '0;
          rt_d    = 1'b0;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      WRITE: begin
        state_d = GAP;
        gap_d   = '0;
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          if (!rt_q && idx_q != LAST_IDX) begin
            idx_d   = idx_q + 1'b1;
            state_d = WRITE;
          end else begin
            // Only a boot-table pass reports completion.
            state_d = IDLE;
            done_d  = !rt_q;
            rt_d    = 1'b0;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      IDLE: begin
        // If start and a runtime request arrive together, start takes priority.
        if (start) begin
          idx_d   = '0;
          rt_d    = 1'b0;
          state_d = WRITE;
        end else if (upd_valid && ready_q) begin
          rt_d      = 1'b1;
          rt_addr_d = upd_addr;
          rt_data_d = upd_data;
          state_d   = WRITE;
        end
      end
      default: state_d = INIT_WAIT;
    endcase

    wr_d    = 1'b0;
    waddr_d = '0;
    wdata_d = '0;
    if (state_d == WRITE) begin
      wr_d    = 1'b1;
      waddr_d = rt_d ? rt_addr_d : rom_addr;
      wdata_d = rt_d ? rt_data_d : rom_data;
    end
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  // State, counters and registered outputs. Reset forces the boot sequence to rerun.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= INIT_WAIT;
      dly_q     <= '0;
      gap_q     <= '0;
      idx_q     <= '0;
      rt_q      <= 1'b0;
      rt_addr_q <= '0;
      rt_data_q <= '0;
      wr_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dly_q     <= dly_d;
      gap_q     <= gap_d;
      idx_q     <= idx_d;
      rt_q      <= rt_d;
      rt_addr_q <= rt_addr_d;
      rt_data_q <= rt_data_d;
      wr_q      <= wr_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign wr        = wr_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign upd_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
